// File: rtl/mult_rom_pkg.sv
// rtl/mult_rom_pkg.sv - shared widths, types and product-table builder for mult_rom
package mult_rom_pkg;

    localparam int OP_W      = 4;
    localparam int RES_W     = 2 * OP_W;
    localparam int ADDR_W    = 2 * OP_W;
    localparam int ROM_DEPTH = 2 ** ADDR_W;

    typedef logic [OP_W-1:0]  operand_t;
    typedef logic [RES_W-1:0] product_t;
    typedef product_t [ROM_DEPTH-1:0] rom_t;

    // Entry i holds (upper operand) * (lower operand), matching the {A,B} address layout.
    function automatic rom_t rom_init();
        rom_t rom;
        int   a;
        int   b;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            a      = i / (2 ** OP_W);
            b      = i % (2 ** OP_W);
            rom[i] = product_t'(a * b);
        end
        return rom;
    endfunction

endpackage

// File: rtl/mult_rom_table.sv
// rtl/mult_rom_table.sv - combinational constant product table, addr -> data
module mult_rom_table
    import mult_rom_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output product_t          data
);

    localparam rom_t ROM = rom_init();

    // Pure lookup; the table is fixed at elaboration and never written.
    always_comb begin
        data = ROM[addr];
    end

endmodule

// File: rtl/mult_rom.sv
// rtl/mult_rom.sv - registered 4x4 unsigned ROM multiplier; MULT_ROM_INREG_EN adds an input register stage
module mult_rom
    import mult_rom_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic [RES_W-1:0] R
);

    logic [ADDR_W-1:0] rom_addr;
    product_t          rom_data;
    product_t          r_d;
    product_t          r_q;

`ifdef MULT_ROM_INREG_EN
    operand_t a_d;
    operand_t a_q;
    operand_t b_d;
    operand_t b_q;

    // Operand capture for the extra pipeline stage.
    always_comb begin
        a_d = A;
        b_d = B;
    end

    // Input stage registers; reset forces zero so X operands never reach the table.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign rom_addr = {a_q, b_q};
`else
    assign rom_addr = {A, B};
`endif

    mult_rom_table u_table (
        .addr (rom_addr),
        .data (rom_data)
    );

    // Next product is simply the table output for the current address.
    always_comb begin
        r_d = rom_data;
    end

    // Output register; reset takes priority over whatever the table presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign R = r_q;

endmodule

// File: tb/tb_mult_rom.sv
// tb/tb_mult_rom.sv - scoreboard bench for mult_rom (honours MULT_ROM_INREG_EN)
module tb_mult_rom;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] R;

    int total;
    int bad;

    logic [7:0] exp_q[$];
    int         id_q[$];
    int         step_id;

`ifdef MULT_ROM_INREG_EN
    logic [7:0] stage_exp;
`endif

    mult_rom dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .R   (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus before the next rising edge and queue the
    // value R must show right after that edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] hexp);
        logic [7:0] out_exp;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
`ifdef MULT_ROM_INREG_EN
        out_exp   = r ? 8'd0 : stage_exp;
        stage_exp = r ? 8'd0 : hexp;
`else
        out_exp   = r ? 8'd0 : hexp;
`endif
        exp_q.push_back(out_exp);
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Monitor: each edge that has a queued expectation is checked just after it.
    initial begin
        logic [7:0] e;
        int         id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                total++;
                if (R !== e) begin
                    bad++;
                    $display("FAIL step%0d R: got %0d expected %0d", id, R, e);
                end
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        step_id = 0;
        rst     = 1'b1;
        A       = 4'bx;
        B       = 4'bx;
`ifdef MULT_ROM_INREG_EN
        stage_exp = 8'd0;
`endif

        // Reset with undriven operands.
        step(1'b1, 4'bx, 4'bx, 8'd0);
        step(1'b1, 4'bx, 4'bx, 8'd0);

        // Basic products.
        step(1'b0, 4'd4,  4'd6,  8'd24);
        step(1'b0, 4'd10, 4'd10, 8'd100);
        step(1'b0, 4'd2,  4'd1,  8'd2);

        // Mid-operation reset, then release.
        step(1'b1, 4'd2,  4'd1,  8'd2);
        step(1'b0, 4'd6,  4'd6,  8'd36);
        step(1'b0, 4'd6,  4'd6,  8'd36);

        // Boundaries.
        step(1'b0, 4'd15, 4'd15, 8'd225);
        step(1'b0, 4'd0,  4'd15, 8'd0);
        step(1'b0, 4'd15, 4'd1,  8'd15);

        // Held operands.
        step(1'b0, 4'd7,  4'd9,  8'd63);
        step(1'b0, 4'd7,  4'd9,  8'd63);
        step(1'b0, 4'd7,  4'd9,  8'd63);

        // Back-to-back sweep of every address.
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 4'(i / 16), 4'(i % 16), 8'((i / 16) * (i % 16)));
        end

        // Flush the pipeline with a held final operand pair.
        step(1'b0, 4'd3, 4'd5, 8'd15);
        step(1'b0, 4'd3, 4'd5, 8'd15);

        // Let the monitor drain, bounded.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            @(posedge clk);
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
